// File: rtl/step_ram_arbiter_pkg.sv
// Shared constants and requester ids for the step RAM arbiter slice.
package step_ram_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 51200;

  typedef enum logic [0:0] {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/step_ram_arbiter_if.sv
// Avalon-style command/response bundle for one requester of the step RAM.
interface step_ram_arbiter_if;
  import step_ram_pkg::*;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output read, write, address, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/step_ram_arbiter_rr_grant.sv
// Fixed-priority grant for the step RAM: B wins unless A has waited MAX_WAIT cycles.
module step_ram_rr_grant
  import step_ram_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic [7:0] i_starve_cnt,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = '0;
    if (i_req_b && (i_starve_cnt < 8'(MAX_WAIT))) begin
      o_grant[REQ_B] = 1'b1;
    end else if (i_req_a) begin
      o_grant[REQ_A] = 1'b1;
    end else if (i_req_b) begin
      o_grant[REQ_B] = 1'b1;
    end
  end

endmodule

// File: rtl/step_ram_arbiter.sv
// Shares the single-port step RAM between the host (A) and the profile sequencer (B),
// with a one-cycle read-return pipeline and out-of-range command squashing.
module step_ram_arbiter
  import step_ram_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  step_ram_arbiter_if.slave  a,
  step_ram_arbiter_if.slave  b,
  output logic [ADDR_W-1:0]  ram_address,
  output logic [BE_W-1:0]    ram_byteenable,
  output logic [DATA_W-1:0]  ram_writedata,
  output logic               ram_chipselect,
  output logic               ram_write,
  output logic               ram_clken,
  input  logic [DATA_W-1:0]  ram_readdata,
  output logic               oor_err
);

  logic              w_reqA;
  logic              w_reqB;
  logic [1:0]        w_grant;
  logic              w_any;
  logic              w_isRead;
  logic              w_isWrite;
  logic              w_oor;
  logic              w_acceptRead;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdData;
  logic              w_validA;
  logic              w_validB;
  req_id_e           w_sel;

  logic [7:0]        r_starveCnt;
  logic              r_rdPend;
  req_id_e           r_rdOwner;
  logic              r_rdOor;

  // Requests are masked while in reset so nothing is granted or driven to the RAM.
  assign w_reqA = reset_n & (a.read | a.write);
  assign w_reqB = reset_n & (b.read | b.write);

  step_ram_rr_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
    .i_req_a      (w_reqA),
    .i_req_b      (w_reqB),
    .i_starve_cnt (r_starveCnt),
    .o_grant      (w_grant)
  );

  always_comb begin
    w_any     = |w_grant;
    w_sel     = w_grant[REQ_B] ? REQ_B : REQ_A;
    w_addr    = '0;
    w_be      = '0;
    w_wdata   = '0;
    w_isWrite = 1'b0;
    w_isRead  = 1'b0;
    if (w_grant[REQ_B]) begin
      w_addr    = b.address;
      w_be      = b.byteenable;
      w_wdata   = b.writedata;
      w_isWrite = b.write;
      w_isRead  = b.read & ~b.write;
    end else if (w_grant[REQ_A]) begin
      w_addr    = a.address;
      w_be      = a.byteenable;
      w_wdata   = a.writedata;
      w_isWrite = a.write;
      w_isRead  = a.read & ~a.write;
    end
    w_oor        = w_any & (w_addr >= ADDR_W'(DEPTH));
    w_acceptRead = w_any & w_isRead;
  end

  assign ram_address    = w_addr;
  assign ram_byteenable = w_be;
  assign ram_writedata  = w_wdata;
  assign ram_chipselect = w_any & ~w_oor;
  assign ram_write      = w_any & ~w_oor & w_isWrite;
  assign ram_clken      = 1'b1;
  assign oor_err        = w_oor;

  assign a.waitrequest = ~w_grant[REQ_A];
  assign b.waitrequest = ~w_grant[REQ_B];

  // Counts consecutive denied cycles of A; saturating lets A win the next arbitration.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starveCnt <= '0;
    end else if (w_reqA && !w_grant[REQ_A]) begin
      if (r_starveCnt < 8'(MAX_WAIT)) begin
        r_starveCnt <= r_starveCnt + 8'd1;
      end
    end else begin
      r_starveCnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdPend  <= 1'b0;
      r_rdOwner <= REQ_A;
      r_rdOor   <= 1'b0;
    end else begin
      r_rdPend <= w_acceptRead;
      if (w_acceptRead) begin
        r_rdOwner <= w_sel;
        r_rdOor   <= w_oor;
      end
    end
  end

  // Gating with reset_n drops a read whose return would land during reset.
  assign w_rdData = r_rdOor ? '0 : ram_readdata;
  assign w_validA = reset_n & r_rdPend & (r_rdOwner == REQ_A);
  assign w_validB = reset_n & r_rdPend & (r_rdOwner == REQ_B);

  assign a.readdatavalid = w_validA;
  assign b.readdatavalid = w_validB;
  assign a.readdata      = w_validA ? w_rdData : '0;
  assign b.readdata      = w_validB ? w_rdData : '0;

endmodule

// File: tb/tb_step_ram_arbiter.sv
// Self-checking bench for step_ram_arbiter: directed scenarios plus randomized traffic
// against a word-level reference memory and arbitration model.
module tb_step_ram_arbiter;
  import step_ram_pkg::*;

  localparam int MAX_WAIT = 8;
  localparam logic [15:0] DEPTH_W = 16'd51200;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect;
  logic        ram_write;
  logic        ram_clken;
  logic [31:0] ram_readdata;
  logic        oor_err;

  step_ram_arbiter_if aIf ();
  step_ram_arbiter_if bIf ();

  step_ram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .a              (aIf),
    .b              (bIf),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .oor_err        (oor_err)
  );

  always #5 clk = ~clk;

  // Stand-in step RAM: registered address, unregistered q.
  logic [31:0] ramMem [0:51199];
  logic [31:0] ramQ;
  assign ram_readdata = ramQ;

  always @(posedge clk) begin
    if (ram_chipselect && ram_address < DEPTH_W) begin
      if (ram_write) begin
        for (int i = 0; i < 4; i++) begin
          if (ram_byteenable[i]) ramMem[ram_address][i*8 +: 8] <= ram_writedata[i*8 +: 8];
        end
      end
      ramQ <= ramMem[ram_address];
    end
  end

  int          errors = 0;
  int          checks = 0;
  cmd_t        cmdA;
  cmd_t        cmdB;
  logic        rstn;
  logic [31:0] refMem [0:51199];
  int          aWait;
  bit          expPend;
  bit          expOwnerB;
  logic [31:0] expData;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    reset_n           = rstn;
    aIf.read          = cmdA.rd;
    aIf.write         = cmdA.wr;
    aIf.address       = cmdA.addr;
    aIf.byteenable    = cmdA.be;
    aIf.writedata     = cmdA.data;
    bIf.read          = cmdB.rd;
    bIf.write         = cmdB.wr;
    bIf.address       = cmdB.addr;
    bIf.byteenable    = cmdB.be;
    bIf.writedata     = cmdB.data;
    #2;
  endtask

  // One cycle: drive, compare against the model's prediction, advance the model.
  task automatic runCycle();
    bit   reqA, reqB, gA, gB, any, oor, vA, vB;
    cmd_t c;
    applyStimulus();
    reqA = rstn && (cmdA.rd || cmdA.wr);
    reqB = rstn && (cmdB.rd || cmdB.wr);
    gA = 0;
    gB = 0;
    if (reqB && aWait < MAX_WAIT) gB = 1;
    else if (reqA) gA = 1;
    else if (reqB) gB = 1;
    any = gA || gB;
    c = gB ? cmdB : cmdA;
    oor = any && (c.addr >= DEPTH_W);
    checkOutput("a_waitrequest", 32'(aIf.waitrequest), 32'(!gA));
    checkOutput("b_waitrequest", 32'(bIf.waitrequest), 32'(!gB));
    checkOutput("ram_chipselect", 32'(ram_chipselect), 32'(any && !oor));
    checkOutput("ram_write", 32'(ram_write), 32'(any && !oor && c.wr));
    checkOutput("oor_err", 32'(oor_err), 32'(oor));
    checkOutput("ram_clken", 32'(ram_clken), 32'd1);
    if (any && !oor) checkOutput("ram_address", 32'(ram_address), 32'(c.addr));
    if (any && !oor && c.wr) begin
      checkOutput("ram_byteenable", 32'(ram_byteenable), 32'(c.be));
      checkOutput("ram_writedata", ram_writedata, c.data);
    end
    vA = rstn && expPend && !expOwnerB;
    vB = rstn && expPend && expOwnerB;
    checkOutput("a_readdatavalid", 32'(aIf.readdatavalid), 32'(vA));
    checkOutput("b_readdatavalid", 32'(bIf.readdatavalid), 32'(vB));
    checkOutput("a_readdata", aIf.readdata, vA ? expData : 32'd0);
    checkOutput("b_readdata", bIf.readdata, vB ? expData : 32'd0);
    if (!rstn) begin
      aWait   = 0;
      expPend = 0;
    end else begin
      if (reqA && !gA) begin
        if (aWait < MAX_WAIT) aWait++;
      end else begin
        aWait = 0;
      end
      expPend = any && c.rd && !c.wr;
      if (expPend) begin
        expOwnerB = gB;
        expData   = oor ? 32'd0 : refMem[c.addr];
      end
      if (any && c.wr && !oor) begin
        for (int i = 0; i < 4; i++) begin
          if (c.be[i]) refMem[c.addr][i*8 +: 8] = c.data[i*8 +: 8];
        end
      end
    end
  endtask

  function automatic cmd_t mkCmd(input bit rd, input bit wr, input logic [15:0] addr,
                                 input logic [3:0] be, input logic [31:0] data);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = addr; c.be = be; c.data = data;
    return c;
  endfunction

  initial begin
    int waited;
    bit granted;
    for (int i = 0; i < 51200; i++) begin
      ramMem[i] = 32'd0;
      refMem[i] = 32'd0;
    end
    ramQ      = 32'd0;
    aWait     = 0;
    expPend   = 0;
    expOwnerB = 0;
    expData   = 32'd0;
    rstn      = 1'b0;
    cmdA      = mkCmd(1, 0, 16'h0001, 4'hF, 32'd0);
    cmdB      = mkCmd(1, 0, 16'h0002, 4'hF, 32'd0);
    reset_n   = 1'b0;
    aIf.read = 0; aIf.write = 0; aIf.address = '0; aIf.byteenable = '0; aIf.writedata = '0;
    bIf.read = 0; bIf.write = 0; bIf.address = '0; bIf.byteenable = '0; bIf.writedata = '0;

    // Reset held with both ports requesting
    repeat (3) begin
      runCycle();
      checkOutput("rst_a_wait", 32'(aIf.waitrequest), 32'd1);
      checkOutput("rst_b_wait", 32'(bIf.waitrequest), 32'd1);
      checkOutput("rst_cs", 32'(ram_chipselect), 32'd0);
    end
    rstn = 1'b1;
    runCycle();
    checkOutput("release_b_first", 32'(bIf.waitrequest), 32'd0);
    checkOutput("release_a_wait", 32'(aIf.waitrequest), 32'd1);
    cmdA = '0; cmdB = '0;
    runCycle();

    // Single B write then read
    cmdB = mkCmd(0, 1, 16'h0010, 4'hF, 32'hDEADBEEF);
    runCycle();
    cmdB = mkCmd(1, 0, 16'h0010, 4'hF, 32'd0);
    runCycle();
    cmdB = '0;
    runCycle();
    checkOutput("b_read_valid", 32'(bIf.readdatavalid), 32'd1);
    checkOutput("b_read_data", bIf.readdata, 32'hDEADBEEF);
    checkOutput("a_not_valid", 32'(aIf.readdatavalid), 32'd0);

    // Byte lanes
    cmdA = mkCmd(0, 1, 16'h0020, 4'hF, 32'h11223344);
    runCycle();
    cmdA = mkCmd(0, 1, 16'h0020, 4'h2, 32'hAABBCCDD);
    runCycle();
    cmdA = mkCmd(1, 1'b0, 16'h0020, 4'hF, 32'd0);
    runCycle();
    cmdA = '0;
    runCycle();
    checkOutput("byte_lane_data", aIf.readdata, 32'h1122CC44);

    // Starvation bound
    waited  = 0;
    granted = 0;
    cmdA = mkCmd(1, 0, 16'h0020, 4'hF, 32'd0);
    for (int i = 0; i < 20 && !granted; i++) begin
      cmdB = mkCmd(1, 0, 16'h0010 + 16'(i % 4), 4'hF, 32'd0);
      runCycle();
      waited++;
      if (aIf.waitrequest === 1'b0) granted = 1;
    end
    checkOutput("starve_grant_cycle", 32'(waited), 32'd9);
    runCycle();
    checkOutput("b_resumes", 32'(bIf.waitrequest), 32'd0);
    cmdA = '0; cmdB = '0;
    runCycle();

    // Out of range accesses and the last valid word
    cmdA = mkCmd(1, 0, 16'hC800, 4'hF, 32'd0);
    runCycle();
    checkOutput("oor_pulse", 32'(oor_err), 32'd1);
    checkOutput("oor_cs", 32'(ram_chipselect), 32'd0);
    checkOutput("oor_accept", 32'(aIf.waitrequest), 32'd0);
    cmdA = mkCmd(0, 1, 16'hFFFF, 4'hF, 32'h55555555);
    runCycle();
    checkOutput("oor_rd_valid", 32'(aIf.readdatavalid), 32'd1);
    checkOutput("oor_rd_data", aIf.readdata, 32'd0);
    checkOutput("oor_wr_blocked", 32'(ram_write), 32'd0);
    cmdA = mkCmd(0, 1, 16'd51199, 4'hF, 32'hCAFEF00D);
    runCycle();
    cmdA = mkCmd(1, 0, 16'd51199, 4'hF, 32'd0);
    runCycle();
    cmdA = '0;
    runCycle();
    checkOutput("last_word_data", aIf.readdata, 32'hCAFEF00D);

    // Reset arriving right after a read is accepted
    cmdB = mkCmd(1, 0, 16'h0010, 4'hF, 32'd0);
    runCycle();
    cmdB = '0;
    rstn = 1'b0;
    runCycle();
    checkOutput("midrst_no_valid", 32'(bIf.readdatavalid), 32'd0);
    rstn = 1'b1;
    runCycle();
    checkOutput("midrst_after_valid", 32'(bIf.readdatavalid), 32'd0);
    checkOutput("midrst_after_cs", 32'(ram_chipselect), 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      cmd_t c [2];
      for (int p = 0; p < 2; p++) begin
        c[p].rd   = 1'($urandom_range(0, 1));
        c[p].wr   = ($urandom_range(0, 3) == 0);
        c[p].be   = 4'($urandom);
        c[p].data = $urandom;
        case ($urandom_range(0, 4))
          0:       c[p].addr = 16'(51198 + $urandom_range(0, 3));
          1:       c[p].addr = 16'hFFFF;
          default: c[p].addr = 16'h0010 + 16'($urandom_range(0, 15));
        endcase
      end
      cmdA = c[0];
      cmdB = c[1];
      rstn = ($urandom_range(0, 49) != 0);
      runCycle();
    end
    rstn = 1'b1;
    cmdA = '0; cmdB = '0;
    runCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
